// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU sequencer: op codes, ALUOp/Funct7 encodings, FSM states.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_XOR    = 5'b00011,
    OP_SLL    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_SUB    = 5'b00110,
    OP_SLT    = 5'b00111,
    OP_SLTU   = 5'b01000,
    OP_PASSB  = 5'b01001,
    OP_SRA    = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_MULDIV = 2'b01,
    S_DONE   = 2'b10
  } state_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RI     = 2'b10;
  localparam logic [1:0] ALUOP_JL     = 2'b11;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;

  // M-extension sub-op, equal to funct3 and to the low bits of OP_MUL..OP_REMU
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 1 bit/cycle multiplier (shift-add) and restoring divider on operand magnitudes.
// Result is valid combinationally in the cycle done is high (last iteration, sign fixed).
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      mop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic            neg_q, neg_d;
  logic [2:0]      mop_q, mop_d;

  logic            signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, hi_step, lo_step, quo_fix, rem_fix;
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    signed_a = (mop == MD_MULH) || (mop == MD_MULHSU) || (mop == MD_DIV) || (mop == MD_REM);
    signed_b = (mop == MD_MULH) || (mop == MD_DIV) || (mop == MD_REM);
    a_neg    = signed_a && a[XLEN-1];
    b_neg    = signed_b && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
  end

  // mop_q[2]=1 selects divide: hi holds the partial remainder, lo shifts dividend out / quotient in
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    div_rs   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rs - {1'b0, m_q};
    if (mop_q[2]) begin
      if (!div_diff[XLEN]) begin
        hi_step = div_diff[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = div_rs[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {hi_step, lo_step};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_step : lo_step;
    rem_fix  = neg_q ? -hi_step : hi_step;
    done     = busy_q && (cnt_q == CW'(XLEN - 1));
    case (mop_q)
      MD_MUL:                       result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;
    neg_d  = neg_q;
    mop_d  = mop_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = mop[2] ? a_mag : b_mag;
      m_d    = mop[2] ? b_mag : a_mag;
      neg_d  = (mop == MD_REM) ? a_neg : (a_neg ^ b_neg);
      mop_d  = mop;
    end else if (busy_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      neg_q  <= 1'b0;
      mop_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      m_q    <= m_d;
      neg_q  <= neg_d;
      mop_q  <= mop_d;
    end
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// EX-stage ALU: decodes ALUOp/Funct3/Funct7, runs single-cycle ops inline and M ops in muldiv_iter.
// state    | meaning
// S_IDLE   | no result held, ready for an op
// S_MULDIV | iterative mul/div in progress, input stalled
// S_DONE   | result valid, waiting for out_ready
module alu_exec_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            r_type,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      operation,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      operation_q, operation_d;
  logic            zero_q, zero_d, illegal_q, illegal_d;

  alu_op_e         op_dec;
  logic            illegal_dec, is_m, md_special, m_iter, accept, md_done;
  logic [XLEN-1:0] fast_res, md_result;
  logic [SHW-1:0]  shamt;

  always_comb begin
    op_dec      = OP_ADD;
    illegal_dec = 1'b0;
    is_m        = 1'b0;
    case (alu_op)
      ALUOP_MEM:    op_dec = OP_ADD;
      ALUOP_BRANCH: op_dec = OP_SUB;
      ALUOP_JL:     op_dec = OP_PASSB;
      default: begin
        if (r_type && funct7 == FUNCT7_M) begin
          is_m        = 1'b1;
          op_dec      = alu_op_e'({2'b10, funct3});
          illegal_dec = !ENABLE_M;
        end else if (r_type && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT) begin
          illegal_dec = 1'b1;
        end else begin
          case (funct3)
            3'b000:  op_dec = (r_type && funct7[5]) ? OP_SUB : OP_ADD;
            3'b001:  op_dec = OP_SLL;
            3'b010:  op_dec = OP_SLT;
            3'b011:  op_dec = OP_SLTU;
            3'b100:  op_dec = OP_XOR;
            3'b101:  op_dec = funct7[5] ? OP_SRA : OP_SRL;
            3'b110:  op_dec = OP_OR;
            default: op_dec = OP_AND;
          endcase
        end
      end
    endcase
  end

  // Divide-by-zero and signed overflow finish in one cycle instead of iterating
  always_comb begin
    shamt      = src_b[SHW-1:0];
    md_special = is_m && funct3[2] &&
                 ((src_b == '0) || (!funct3[0] && src_a == INT_MIN && src_b == '1));
    m_iter     = is_m && !illegal_dec && !md_special;
    case (op_dec)
      OP_AND:   fast_res = src_a & src_b;
      OP_OR:    fast_res = src_a | src_b;
      OP_ADD:   fast_res = src_a + src_b;
      OP_XOR:   fast_res = src_a ^ src_b;
      OP_SLL:   fast_res = src_a << shamt;
      OP_SRL:   fast_res = src_a >> shamt;
      OP_SUB:   fast_res = src_a - src_b;
      OP_SLT:   fast_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU:  fast_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_PASSB: fast_res = src_b;
      OP_SRA:   fast_res = XLEN'($signed(src_a) >>> shamt);
      default: begin
        if (src_b == '0) fast_res = funct3[1] ? src_a : '1;
        else             fast_res = funct3[1] ? '0 : src_a;
      end
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && m_iter),
    .mop    (funct3),
    .a      (src_a),
    .b      (src_b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      operation_q <= OP_ADD;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      operation_q <= operation_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = m_iter ? S_MULDIV : S_DONE;
      S_MULDIV: if (md_done) state_d = S_DONE;
      S_DONE: begin
        if (accept)         state_d = m_iter ? S_MULDIV : S_DONE;
        else if (out_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    out_valid = (state_q == S_DONE);
    accept    = in_valid && in_ready;
    result    = result_q;
    operation = operation_q;
    zero      = zero_q;
    illegal   = illegal_q;
  end

  always_comb begin
    result_d    = result_q;
    operation_d = operation_q;
    illegal_d   = illegal_q;
    if (accept) begin
      operation_d = op_dec;
      illegal_d   = illegal_dec;
      if (!m_iter) result_d = illegal_dec ? '0 : fast_res;
    end else if (state_q == S_MULDIV && md_done) begin
      result_d = md_result;
    end
    zero_d = (result_d == '0);
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed vector table plus hand-written sequences for backpressure, reset mid-divide and ENABLE_M=0.
module tb_alu_exec_sequencer;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  alu_op = 2'b00;
  logic        r_type = 1'b0;
  logic [6:0]  funct7 = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;

  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic [4:0]  operation;
  logic        nm_in_ready, nm_out_valid, nm_zero, nm_illegal;
  logic [31:0] nm_result;
  logic [4:0]  nm_operation;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  alu_exec_sequencer #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .r_type(r_type), .funct7(funct7), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .operation(operation), .zero(zero), .illegal(illegal)
  );

  alu_exec_sequencer #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nm_in_ready),
    .alu_op(alu_op), .r_type(r_type), .funct7(funct7), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .out_valid(nm_out_valid), .out_ready(out_ready),
    .result(nm_result), .operation(nm_operation), .zero(nm_zero), .illegal(nm_illegal)
  );

  typedef struct packed {
    logic [1:0]  aop;
    logic        rt;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  op;
    logic        zero;
    logic        ill;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] aop, input logic rt, input logic [6:0] f7,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input alu_op_e op, input logic z,
                              input logic ill, input int lat);
    vec_t v;
    v.aop = aop; v.rt = rt; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
    v.res = res; v.op = op; v.zero = z; v.ill = ill; v.lat = 8'(lat);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  task automatic drive(input vec_t v);
    alu_op = v.aop; r_type = v.rt; funct7 = v.f7; funct3 = v.f3;
    src_a = v.a; src_b = v.b;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int busy;
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("vec%0d stall_cycles", idx), 32'(busy), 32'(v.lat) - 32'd1);
    check($sformatf("vec%0d result", idx), result, v.res);
    check($sformatf("vec%0d operation", idx), 32'(operation), 32'(v.op));
    check($sformatf("vec%0d zero", idx), 32'(zero), 32'(v.zero));
    check($sformatf("vec%0d illegal", idx), 32'(illegal), 32'(v.ill));
    @(posedge clk); #1;
    check($sformatf("vec%0d drained", idx), 32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wait_cnt;

    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset operation", 32'(operation), 32'(OP_ADD));
    check("reset zero", 32'(zero), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    //              aop   rt  f7     f3  a             b             result        op         z  ill lat
    vecs.push_back(mk(2'b10, 1, 7'h00, 0, 32'd5,        32'd7,        32'd12,       OP_ADD,    0, 0, 1));
    vecs.push_back(mk(2'b01, 0, 7'h00, 0, 32'h1234,     32'h1234,     32'd0,        OP_SUB,    1, 0, 1));
    vecs.push_back(mk(2'b10, 0, 7'h20, 0, 32'd10,       32'd3,        32'd13,       OP_ADD,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h20, 0, 32'd10,       32'd3,        32'd7,        OP_SUB,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 1, 32'd1,        32'h24,       32'h10,       OP_SLL,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 5, 32'h80000000, 32'd4,        32'h08000000, OP_SRL,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 5, 32'h80000000, 32'h21,       32'h40000000, OP_SRL,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h20, 5, 32'h80000000, 32'd4,        32'hF8000000, OP_SRA,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 2, 32'hFFFFFFFF, 32'd1,        32'd1,        OP_SLT,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 3, 32'hFFFFFFFF, 32'd1,        32'd0,        OP_SLTU,   1, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 4, 32'hF0F0,     32'h0FF0,     32'hFF00,     OP_XOR,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 6, 32'hF000,     32'h000F,     32'hF00F,     OP_OR,     0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h00, 7, 32'hFF00,     32'h0FF0,     32'h0F00,     OP_AND,    0, 0, 1));
    vecs.push_back(mk(2'b11, 0, 7'h00, 0, 32'h55,       32'hABCD,     32'hABCD,     OP_PASSB,  0, 0, 1));
    vecs.push_back(mk(2'b00, 0, 7'h00, 2, 32'h100,      32'h20,       32'h120,      OP_ADD,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h02, 0, 32'd4,        32'd5,        32'd0,        OP_ADD,    1, 1, 1));
    vecs.push_back(mk(2'b10, 1, 7'h01, 0, 32'd7,        32'd6,        32'd42,       OP_MUL,    0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, OP_MUL,    0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, OP_MULH,   0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULHSU, 0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 3, 32'hFFFFFFFF, 32'd2,        32'd1,        OP_MULHU,  0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, OP_DIV,    0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 5, 32'd100,      32'd7,        32'd14,       OP_DIVU,   0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, OP_REM,    0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 7, 32'd100,      32'd7,        32'd2,        OP_REMU,   0, 0, 33));
    vecs.push_back(mk(2'b10, 1, 7'h01, 4, 32'd7,        32'd0,        32'hFFFFFFFF, OP_DIV,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h01, 6, 32'd7,        32'd0,        32'd7,        OP_REM,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h01, 5, 32'd7,        32'd0,        32'hFFFFFFFF, OP_DIVU,   0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h01, 7, 32'd7,        32'd0,        32'd7,        OP_REMU,   0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h01, 4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, OP_DIV,    0, 0, 1));
    vecs.push_back(mk(2'b10, 1, 7'h01, 6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        OP_REM,    1, 0, 1));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: result held while a second op waits, then accepted on release
    drive(mk(2'b10, 1, 7'h00, 0, 32'd1, 32'd2, 32'd0, OP_ADD, 0, 0, 1));
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp first out_valid", 32'(out_valid), 32'd1);
    drive(mk(2'b10, 1, 7'h00, 4, 32'd5, 32'd3, 32'd0, OP_XOR, 0, 0, 1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d result", k), result, 32'd3);
      check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
    end
    check("bp hold operation", 32'(operation), 32'(OP_ADD));
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp second result", result, 32'd6);
    check("bp second operation", 32'(operation), 32'(OP_XOR));
    check("bp second out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp drained", 32'(out_valid), 32'd0);

    // Reset during DIVU iterations discards the operation
    drive(mk(2'b10, 1, 7'h01, 5, 32'd100, 32'd7, 32'd0, OP_DIVU, 0, 0, 1));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid-divu in_ready low", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst-divu out_valid", 32'(out_valid), 32'd0);
    check("rst-divu in_ready", 32'(in_ready), 32'd1);
    check("rst-divu result", result, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("rst-divu no late result", 32'(out_valid), 32'd0);
    run_vec(mk(2'b10, 1, 7'h00, 0, 32'd1, 32'd1, 32'd2, OP_ADD, 0, 0, 1), 100);

    // ENABLE_M=0 instance flags MUL illegal in one cycle; the M-enabled instance still multiplies
    drive(mk(2'b10, 1, 7'h01, 0, 32'd7, 32'd6, 32'd0, OP_MUL, 0, 0, 1));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("nom out_valid", 32'(nm_out_valid), 32'd1);
    check("nom illegal", 32'(nm_illegal), 32'd1);
    check("nom result", nm_result, 32'd0);
    check("m-enabled busy", 32'(in_ready), 32'd0);
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("m-enabled mul result", result, 32'd42);
    check("m-enabled mul illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
